decode_ctrl_pipe: RTL and testbench

Decode-stage control and ID/EX pipeline boundary for a 5-stage RV32I-subset pipeline. It applies a hazard bubble select to the instruction before control decode and decodes opcode/funct3/funct7b5 into datapath controls. It then registers the decode-stage data, register specifiers and controls into the execute stage. The register file and sign extender sit outside; this block supplies their immediate-format select.

---
 rtl/decode_ctrl_pipe_if.sv | 51 +++++
 rtl/decode_ctrl_pipe.sv | 174 +++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/decode_ctrl_pipe_if.sv
// Decode/execute boundary bundle: decode-stage inputs, decode-side combinational
// outputs and the registered execute-stage controls and data.
interface decode_ctrl_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              bubble_d;
  logic [31:0]       instr_d;
  logic [XLEN-1:0]   pc_d;
  logic [XLEN-1:0]   pc_plus4_d;
  logic [XLEN-1:0]   rd1_d;
  logic [XLEN-1:0]   rd2_d;
  logic [XLEN-1:0]   imm_ext_d;

  logic [1:0]        imm_src_d;
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;

  logic [XLEN-1:0]   pc_e;
  logic [XLEN-1:0]   pc_plus4_e;
  logic [XLEN-1:0]   rd1_e;
  logic [XLEN-1:0]   rd2_e;
  logic [XLEN-1:0]   imm_ext_e;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic [2:0]        alu_control_e;
  logic [1:0]        result_src_e;
  logic              reg_write_e;
  logic              mem_write_e;
  logic              mem_read_e;
  logic              jump_e;
  logic              branch_e;
  logic              alu_src_e;

  modport master (
    output bubble_d, instr_d, pc_d, pc_plus4_d, rd1_d, rd2_d, imm_ext_d,
    input  imm_src_d, rs1_d, rs2_d,
    input  pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e,
    input  alu_control_e, result_src_e, reg_write_e, mem_write_e, mem_read_e,
    input  jump_e, branch_e, alu_src_e
  );

  modport slave (
    input  bubble_d, instr_d, pc_d, pc_plus4_d, rd1_d, rd2_d, imm_ext_d,
    output imm_src_d, rs1_d, rs2_d,
    output pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e,
    output alu_control_e, result_src_e, reg_write_e, mem_write_e, mem_read_e,
    output jump_e, branch_e, alu_src_e
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// RV32I-subset decode control plus ID/EX pipeline register.
// Optional IDEX_FLUSH_EN adds a flush_e input that clears the ID/EX register.
module decode_ctrl_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic clk,
  input  logic reset,
`ifdef IDEX_FLUSH_EN
  input  logic flush_e,
`endif
  decode_ctrl_pipe_if.slave bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Bubble only affects the control-relevant fields; register fields stay live.
  logic [6:0] opcode_c;
  logic [2:0] funct3_c;
  logic       funct7b5_c;
  assign opcode_c   = bus.bubble_d ? 7'd0 : bus.instr_d[6:0];
  assign funct3_c   = bus.bubble_d ? 3'd0 : bus.instr_d[14:12];
  assign funct7b5_c = bus.bubble_d ? 1'b0 : bus.instr_d[30];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr_d[31], bus.instr_d[29:25]};

  logic       reg_write_c, alu_src_c, mem_write_c, mem_read_c, branch_c, jump_c;
  logic [1:0] imm_src_c, result_src_c, alu_op_c;
  logic [2:0] alu_control_c;

  always_comb begin
    reg_write_c  = 1'b0;
    imm_src_c    = 2'b00;
    alu_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    result_src_c = 2'b00;
    branch_c     = 1'b0;
    jump_c       = 1'b0;
    alu_op_c     = 2'b00;
    case (opcode_c)
      OP_LW: begin
        reg_write_c  = 1'b1;
        alu_src_c    = 1'b1;
        mem_read_c   = 1'b1;
        result_src_c = 2'b01;
      end
      OP_SW: begin
        imm_src_c   = 2'b01;
        alu_src_c   = 1'b1;
        mem_write_c = 1'b1;
      end
      OP_R: begin
        reg_write_c = 1'b1;
        alu_op_c    = 2'b10;
      end
      OP_BEQ: begin
        imm_src_c = 2'b10;
        branch_c  = 1'b1;
        alu_op_c  = 2'b01;
      end
      OP_IALU: begin
        reg_write_c = 1'b1;
        alu_src_c   = 1'b1;
        alu_op_c    = 2'b10;
      end
      OP_JAL: begin
        reg_write_c  = 1'b1;
        imm_src_c    = 2'b11;
        result_src_c = 2'b10;
        jump_c       = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtract only for R-type with funct7[5]; I-type immediates may set bit 30.
  always_comb begin
    alu_control_c = 3'b000;
    case (alu_op_c)
      2'b01: alu_control_c = 3'b001;
      2'b10: begin
        case (funct3_c)
          3'b000:  alu_control_c = (opcode_c[5] & funct7b5_c) ? 3'b001 : 3'b000;
          3'b010:  alu_control_c = 3'b101;
          3'b110:  alu_control_c = 3'b011;
          3'b111:  alu_control_c = 3'b010;
          default: alu_control_c = 3'b000;
        endcase
      end
      default: alu_control_c = 3'b000;
    endcase
  end

  assign bus.imm_src_d = imm_src_c;
  assign bus.rs1_d     = bus.instr_d[15 +: REG_AW];
  assign bus.rs2_d     = bus.instr_d[20 +: REG_AW];

  logic clear_e;
`ifdef IDEX_FLUSH_EN
  assign clear_e = reset | flush_e;
`else
  assign clear_e = reset;
`endif

  logic [XLEN-1:0]   pc_e_reg, pc_plus4_e_reg, rd1_e_reg, rd2_e_reg, imm_ext_e_reg;
  logic [REG_AW-1:0] rs1_e_reg, rs2_e_reg, rd_e_reg;
  logic [2:0]        alu_control_e_reg;
  logic [1:0]        result_src_e_reg;
  logic              reg_write_e_reg, mem_write_e_reg, mem_read_e_reg;
  logic              jump_e_reg, branch_e_reg, alu_src_e_reg;

  always_ff @(posedge clk) begin
    if (clear_e) begin
      pc_e_reg          <= '0;
      pc_plus4_e_reg    <= '0;
      rd1_e_reg         <= '0;
      rd2_e_reg         <= '0;
      imm_ext_e_reg     <= '0;
      rs1_e_reg         <= '0;
      rs2_e_reg         <= '0;
      rd_e_reg          <= '0;
      alu_control_e_reg <= '0;
      result_src_e_reg  <= '0;
      reg_write_e_reg   <= 1'b0;
      mem_write_e_reg   <= 1'b0;
      mem_read_e_reg    <= 1'b0;
      jump_e_reg        <= 1'b0;
      branch_e_reg      <= 1'b0;
      alu_src_e_reg     <= 1'b0;
    end else begin
      pc_e_reg          <= bus.pc_d;
      pc_plus4_e_reg    <= bus.pc_plus4_d;
      rd1_e_reg         <= bus.rd1_d;
      rd2_e_reg         <= bus.rd2_d;
      imm_ext_e_reg     <= bus.imm_ext_d;
      rs1_e_reg         <= bus.instr_d[15 +: REG_AW];
      rs2_e_reg         <= bus.instr_d[20 +: REG_AW];
      rd_e_reg          <= bus.instr_d[7 +: REG_AW];
      alu_control_e_reg <= alu_control_c;
      result_src_e_reg  <= result_src_c;
      reg_write_e_reg   <= reg_write_c;
      mem_write_e_reg   <= mem_write_c;
      mem_read_e_reg    <= mem_read_c;
      jump_e_reg        <= jump_c;
      branch_e_reg      <= branch_c;
      alu_src_e_reg     <= alu_src_c;
    end
  end

  assign bus.pc_e          = pc_e_reg;
  assign bus.pc_plus4_e    = pc_plus4_e_reg;
  assign bus.rd1_e         = rd1_e_reg;
  assign bus.rd2_e         = rd2_e_reg;
  assign bus.imm_ext_e     = imm_ext_e_reg;
  assign bus.rs1_e         = rs1_e_reg;
  assign bus.rs2_e         = rs2_e_reg;
  assign bus.rd_e          = rd_e_reg;
  assign bus.alu_control_e = alu_control_e_reg;
  assign bus.result_src_e  = result_src_e_reg;
  assign bus.reg_write_e   = reg_write_e_reg;
  assign bus.mem_write_e   = mem_write_e_reg;
  assign bus.mem_read_e    = mem_read_e_reg;
  assign bus.jump_e        = jump_e_reg;
  assign bus.branch_e      = branch_e_reg;
  assign bus.alu_src_e     = alu_src_e_reg;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed self-checking bench for decode_ctrl_pipe; define IDEX_FLUSH_EN
// to also exercise the flush input.
module tb_decode_ctrl_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_ctrl_pipe_if #(.XLEN(32), .REG_AW(5)) dbus ();

`ifdef IDEX_FLUSH_EN
  logic flush_e;
`endif

  decode_ctrl_pipe #(.XLEN(32), .REG_AW(5)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef IDEX_FLUSH_EN
    .flush_e (flush_e),
`endif
    .bus     (dbus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic bub, input logic [31:0] pc);
    dbus.instr_d    = ins;
    dbus.bubble_d   = bub;
    dbus.pc_d       = pc;
    dbus.pc_plus4_d = pc + 32'd4;
    dbus.rd1_d      = pc + 32'h1000_0000;
    dbus.rd2_d      = pc + 32'h2000_0000;
    dbus.imm_ext_d  = pc + 32'h0300_0000;
  endtask

  task automatic check_zero(input string name);
    check({name, ".pc_e"},          dbus.pc_e, 32'h0);
    check({name, ".pc_plus4_e"},    dbus.pc_plus4_e, 32'h0);
    check({name, ".rd1_e"},         dbus.rd1_e, 32'h0);
    check({name, ".rd2_e"},         dbus.rd2_e, 32'h0);
    check({name, ".imm_ext_e"},     dbus.imm_ext_e, 32'h0);
    check({name, ".rs1_e"},         32'(dbus.rs1_e), 32'h0);
    check({name, ".rs2_e"},         32'(dbus.rs2_e), 32'h0);
    check({name, ".rd_e"},          32'(dbus.rd_e), 32'h0);
    check({name, ".alu_control_e"}, 32'(dbus.alu_control_e), 32'h0);
    check({name, ".result_src_e"},  32'(dbus.result_src_e), 32'h0);
    check({name, ".ctrl_bits"},
          32'({dbus.reg_write_e, dbus.mem_write_e, dbus.mem_read_e,
               dbus.jump_e, dbus.branch_e, dbus.alu_src_e}), 32'h0);
  endtask

  // Control expectation order: reg_write, mem_write, mem_read, branch, jump, alu_src.
  task automatic run(input string name, input logic [31:0] ins, input logic bub,
                     input logic [31:0] pc, input logic [1:0] exp_imm,
                     input logic [4:0] exp_rs1, input logic [4:0] exp_rs2,
                     input logic [4:0] exp_rd, input logic [5:0] exp_ctrl,
                     input logic [1:0] exp_rsrc, input logic [2:0] exp_alu);
    drive(ins, bub, pc);
    #1;
    $display("[TB] %s instr=0x%08h bubble=%0b pc=0x%0h", name, ins, bub, pc);
    check({name, ".imm_src_d"}, 32'(dbus.imm_src_d), 32'(exp_imm));
    check({name, ".rs1_d"},     32'(dbus.rs1_d), 32'(exp_rs1));
    check({name, ".rs2_d"},     32'(dbus.rs2_d), 32'(exp_rs2));
    @(posedge clk);
    #1;
    check({name, ".ctrl_bits"},
          32'({dbus.reg_write_e, dbus.mem_write_e, dbus.mem_read_e,
               dbus.branch_e, dbus.jump_e, dbus.alu_src_e}), 32'(exp_ctrl));
    check({name, ".result_src_e"},  32'(dbus.result_src_e), 32'(exp_rsrc));
    check({name, ".alu_control_e"}, 32'(dbus.alu_control_e), 32'(exp_alu));
    check({name, ".rs1_e"},         32'(dbus.rs1_e), 32'(exp_rs1));
    check({name, ".rs2_e"},         32'(dbus.rs2_e), 32'(exp_rs2));
    check({name, ".rd_e"},          32'(dbus.rd_e), 32'(exp_rd));
    check({name, ".pc_e"},          dbus.pc_e, pc);
    check({name, ".pc_plus4_e"},    dbus.pc_plus4_e, pc + 32'd4);
    check({name, ".rd1_e"},         dbus.rd1_e, pc + 32'h1000_0000);
    check({name, ".rd2_e"},         dbus.rd2_e, pc + 32'h2000_0000);
    check({name, ".imm_ext_e"},     dbus.imm_ext_e, pc + 32'h0300_0000);
  endtask

  initial begin
`ifdef IDEX_FLUSH_EN
    flush_e = 1'b0;
`endif
    reset = 1'b1;
    drive(32'h0080A283, 1'b0, 32'h1234);
    @(posedge clk);
    #1;
    $display("[TB] reset with lw on inputs");
    check_zero("reset");
    reset = 1'b0;

    //   name        instr         bub  pc      imm    rs1 rs2 rd  ctrl        rsrc   alu
    run("add",   32'h002081B3, 1'b0, 32'h100, 2'b00, 1, 2, 3,  6'b100000, 2'b00, 3'b000);
    run("sub",   32'h402081B3, 1'b0, 32'h104, 2'b00, 1, 2, 3,  6'b100000, 2'b00, 3'b001);
    run("and",   32'h0020F1B3, 1'b0, 32'h108, 2'b00, 1, 2, 3,  6'b100000, 2'b00, 3'b010);
    run("sll",   32'h002091B3, 1'b0, 32'h10C, 2'b00, 1, 2, 3,  6'b100000, 2'b00, 3'b000);
    run("lw",    32'h0080A283, 1'b0, 32'h110, 2'b00, 1, 8, 5,  6'b101001, 2'b01, 3'b000);
    run("sw",    32'h0020A223, 1'b0, 32'h114, 2'b01, 1, 2, 4,  6'b010001, 2'b00, 3'b000);
    run("beq",   32'h00208463, 1'b0, 32'h118, 2'b10, 1, 2, 8,  6'b000100, 2'b00, 3'b001);
    run("jal",   32'h008000EF, 1'b0, 32'h11C, 2'b11, 0, 8, 1,  6'b100010, 2'b10, 3'b000);
    run("ori",   32'h0050E213, 1'b0, 32'h120, 2'b00, 1, 5, 4,  6'b100001, 2'b00, 3'b011);
    run("slti",  32'h0050A213, 1'b0, 32'h124, 2'b00, 1, 5, 4,  6'b100001, 2'b00, 3'b101);
    run("addi_b30", 32'h40008093, 1'b0, 32'h128, 2'b00, 1, 0, 1, 6'b100001, 2'b00, 3'b000);
    run("bubble_lw", 32'h0080A283, 1'b1, 32'h40, 2'b00, 1, 8, 5, 6'b000000, 2'b00, 3'b000);
    run("bubble_sub", 32'h402081B3, 1'b1, 32'h44, 2'b00, 1, 2, 3, 6'b000000, 2'b00, 3'b000);
    run("unknown", 32'h0000007F, 1'b0, 32'h130, 2'b00, 0, 0, 0,  6'b000000, 2'b00, 3'b000);
    run("lw2",   32'h0080A283, 1'b0, 32'h134, 2'b00, 1, 8, 5,  6'b101001, 2'b01, 3'b000);

    reset = 1'b1;
    drive(32'h0080A283, 1'b0, 32'h138);
    @(posedge clk);
    #1;
    $display("[TB] mid-stream reset with lw");
    check_zero("mid_reset");
    reset = 1'b0;
    run("post_reset_add", 32'h002081B3, 1'b0, 32'h13C, 2'b00, 1, 2, 3, 6'b100000, 2'b00, 3'b000);

`ifdef IDEX_FLUSH_EN
    flush_e = 1'b1;
    drive(32'h002081B3, 1'b0, 32'h200);
    @(posedge clk);
    #1;
    $display("[TB] flush with add");
    check_zero("flush");
    flush_e = 1'b0;
    run("post_flush_add", 32'h002081B3, 1'b0, 32'h204, 2'b00, 1, 2, 3, 6'b100000, 2'b00, 3'b000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
